// File: rtl/dot_scale_acc.sv
// Block-scaled group accumulator behind dot_fp_spec.
// Aligns each dot product to a running E8M0 exponent and sums a group of blocks.
module dot_scale_acc #(
  parameter int in_width    = 43,
  parameter int scale_width = 8,
  parameter int max_blocks  = 16,
  parameter int acc_width   = in_width + $clog2(max_blocks),
  parameter int cnt_width   = $clog2(max_blocks + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [in_width-1:0]  i_dp,
  input  logic                 i_nan,
  input  logic [scale_width-1:0] i_xa,
  input  logic [scale_width-1:0] i_xb,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [acc_width-1:0] o_acc,
  output logic [9:0]           o_exp,
  output logic                 o_nan,
  output logic [cnt_width-1:0] o_cnt,
  output logic                 o_trunc
);

  localparam int EW = scale_width + 1;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic signed [acc_width-1:0] acc_q, acc_d;
  logic [EW-1:0]        acc_e_q, acc_e_d;
  logic                 nan_q, nan_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 trunc_q, trunc_d;

  // Arithmetic right shift that saturates to the sign for huge distances.
  function automatic logic signed [acc_width-1:0] asr(
    input logic signed [acc_width-1:0] x,
    input logic [EW-1:0]               sh
  );
    if (int'(sh) >= acc_width) begin
      return {acc_width{x[acc_width-1]}};
    end
    return x >>> sh;
  endfunction

  logic [EW-1:0]               beat_e;
  logic                        beat_nan;
  logic signed [acc_width-1:0] dp_ext;
  logic [cnt_width-1:0]        cnt_inc;
  logic                        full;
  logic                        e_gt;
  logic [EW-1:0]               e_diff;
  logic                        out_vld;

  assign beat_e   = EW'(i_xa) + EW'(i_xb);
  assign beat_nan = i_nan | (&i_xa) | (&i_xb);
  assign dp_ext   = acc_width'($signed(i_dp));
  assign cnt_inc  = cnt_q + cnt_width'(1);
  assign full     = (cnt_inc == cnt_width'(max_blocks));
  assign e_gt     = (beat_e > acc_e_q);
  assign e_diff   = e_gt ? (beat_e - acc_e_q) : (acc_e_q - beat_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      acc_e_q <= '0;
      nan_q   <= 1'b0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      acc_e_q <= acc_e_d;
      nan_q   <= nan_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    acc_e_d = acc_e_q;
    nan_d   = nan_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    unique case (state_q)
      ACC: begin
        if (i_valid) begin
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            acc_d   = dp_ext;
            acc_e_d = beat_e;
            nan_d   = beat_nan;
          end else begin
            nan_d = nan_q | beat_nan;
            // Larger exponent wins; the smaller side is shifted down.
            if (e_gt) begin
              acc_d   = asr(acc_q, e_diff) + dp_ext;
              acc_e_d = beat_e;
            end else begin
              acc_d = acc_q + asr(dp_ext, e_diff);
            end
          end
          if (i_last || full) begin
            state_d = OUT;
            trunc_d = ~i_last;
          end
        end
      end
      OUT: begin
        if (o_ready) begin
          state_d = ACC;
          cnt_d   = '0;
          trunc_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign out_vld = (state_q == OUT);
  assign i_ready = (state_q == ACC);
  assign o_valid = out_vld;
  assign o_acc   = out_vld ? acc_q : '0;
  assign o_exp   = out_vld ? (10'(acc_e_q) - 10'd254) : '0;
  assign o_nan   = out_vld & nan_q;
  assign o_cnt   = out_vld ? cnt_q : '0;
  assign o_trunc = out_vld & trunc_q;

endmodule

// File: tb/tb_dot_scale_acc.sv
// Directed bench for dot_scale_acc.
// Inputs change and outputs are sampled on the falling edge.
module tb_dot_scale_acc;

  localparam int IW = 43;
  localparam int AW = 47;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [IW-1:0] i_dp = '0;
  logic          i_nan = 1'b0;
  logic [7:0]    i_xa = '0;
  logic [7:0]    i_xb = '0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [AW-1:0] o_acc;
  logic [9:0]    o_exp;
  logic          o_nan;
  logic [CW-1:0] o_cnt;
  logic          o_trunc;

  int n_chk = 0;
  int n_fail = 0;

  dot_scale_acc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_dp    (i_dp),
    .i_nan   (i_nan),
    .i_xa    (i_xa),
    .i_xb    (i_xb),
    .i_last  (i_last),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_acc   (o_acc),
    .o_exp   (o_exp),
    .o_nan   (o_nan),
    .o_cnt   (o_cnt),
    .o_trunc (o_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [AW-1:0] obs,
                         input logic [AW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic signed [IW-1:0] dp, input logic nan,
                      input logic [7:0] xa, input logic [7:0] xb,
                      input logic last);
    i_valid = 1'b1;
    i_dp    = dp;
    i_nan   = nan;
    i_xa    = xa;
    i_xb    = xb;
    i_last  = last;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic handshake();
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ird", 16'(i_ready), 16'd1);
    chk("rst_ov", 16'(o_valid), 16'd0);
    chk_acc("rst_acc", o_acc, '0);
    chk("rst_cnt", 16'(o_cnt), 16'd0);
    chk("rst_exp", 16'(o_exp), 16'd0);
    chk("rst_nt", 16'({o_nan, o_trunc}), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single beat
    beat(43'sd100, 1'b0, 8'd127, 8'd127, 1'b1);
    chk("s_ov", 16'(o_valid), 16'd1);
    chk("s_ird", 16'(i_ready), 16'd0);
    chk_acc("s_acc", o_acc, AW'(100));
    chk("s_exp", 16'(o_exp), 16'd0);
    chk("s_cnt", 16'(o_cnt), 16'd1);
    chk("s_nt", 16'({o_nan, o_trunc}), 16'd0);
    handshake();

    // equal scales
    beat(43'sd5, 1'b0, 8'd127, 8'd127, 1'b0);
    beat(-43'sd3, 1'b0, 8'd127, 8'd127, 1'b1);
    chk_acc("eq_acc", o_acc, AW'(2));
    chk("eq_exp", 16'(o_exp), 16'd0);
    chk("eq_cnt", 16'(o_cnt), 16'd2);
    handshake();

    // alignment: small exponent first
    beat(43'sd8, 1'b0, 8'd127, 8'd127, 1'b0);
    beat(43'sd1, 1'b0, 8'd128, 8'd127, 1'b1);
    chk_acc("al1_acc", o_acc, AW'(5));
    chk("al1_exp", 16'(o_exp), 16'd1);
    handshake();

    // alignment: large exponent first
    beat(43'sd1, 1'b0, 8'd128, 8'd127, 1'b0);
    beat(43'sd8, 1'b0, 8'd127, 8'd127, 1'b1);
    chk_acc("al2_acc", o_acc, AW'(5));
    chk("al2_exp", 16'(o_exp), 16'd1);
    handshake();

    // floor on negative shift
    beat(-43'sd3, 1'b0, 8'd127, 8'd127, 1'b0);
    beat(43'sd0, 1'b0, 8'd128, 8'd127, 1'b1);
    chk_acc("fl_acc", o_acc, AW'(-2));
    chk("fl_exp", 16'(o_exp), 16'd1);
    handshake();

    // huge shift, positive operand -> 0
    beat(43'sd10, 1'b0, 8'd254, 8'd254, 1'b0);
    beat(43'sd7, 1'b0, 8'd0, 8'd0, 1'b1);
    chk_acc("hp_acc", o_acc, AW'(10));
    chk("hp_exp", 16'(o_exp), 16'd254);
    handshake();

    // huge shift, negative operand -> -1
    beat(43'sd10, 1'b0, 8'd254, 8'd254, 1'b0);
    beat(-43'sd7, 1'b0, 8'd0, 8'd0, 1'b1);
    chk_acc("hn_acc", o_acc, AW'(9));
    handshake();

    // NaN scale on beat 2 of 3
    beat(43'sd1, 1'b0, 8'd127, 8'd127, 1'b0);
    beat(43'sd2, 1'b0, 8'hFF, 8'd127, 1'b0);
    beat(43'sd3, 1'b0, 8'd127, 8'd127, 1'b1);
    chk("nan_nan", 16'(o_nan), 16'd1);
    chk("nan_cnt", 16'(o_cnt), 16'd3);
    handshake();
    beat(43'sd1, 1'b0, 8'd127, 8'd127, 1'b1);
    chk("clean_nan", 16'(o_nan), 16'd0);
    handshake();
    beat(43'sd1, 1'b1, 8'd127, 8'd127, 1'b1);
    chk("inan_nan", 16'(o_nan), 16'd1);
    handshake();

    // backpressure with i_valid held high
    beat(43'sd7, 1'b0, 8'd127, 8'd127, 1'b1);
    i_valid = 1'b1;
    i_dp    = 43'sd99;
    i_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_ird", 16'(i_ready), 16'd0);
      chk("bp_ov", 16'(o_valid), 16'd1);
      chk_acc("bp_acc", o_acc, AW'(7));
      chk("bp_cnt", 16'(o_cnt), 16'd1);
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    i_valid = 1'b0;
    chk("hs_ird", 16'(i_ready), 16'd1);
    chk("hs_ov", 16'(o_valid), 16'd0);
    @(negedge clk);
    chk("hs_idle_ov", 16'(o_valid), 16'd0);

    // truncation at max_blocks
    for (int b = 0; b < 15; b++) beat(43'sd1, 1'b0, 8'd127, 8'd127, 1'b0);
    chk("tr15_ov", 16'(o_valid), 16'd0);
    beat(43'sd1, 1'b0, 8'd127, 8'd127, 1'b0);
    chk("tr_ov", 16'(o_valid), 16'd1);
    chk("tr_cnt", 16'(o_cnt), 16'd16);
    chk("tr_tr", 16'(o_trunc), 16'd1);
    chk_acc("tr_acc", o_acc, AW'(16));
    handshake();
    chk("tr_clr", 16'(o_trunc), 16'd0);

    // reset mid-group
    for (int b = 0; b < 3; b++) beat(43'sd2, 1'b0, 8'd127, 8'd127, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ird", 16'(i_ready), 16'd1);
    chk("mr_ov", 16'(o_valid), 16'd0);
    chk_acc("mr_acc", o_acc, '0);
    chk("mr_cnt", 16'(o_cnt), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(43'sd4, 1'b0, 8'd127, 8'd127, 1'b1);
    chk("fr_cnt", 16'(o_cnt), 16'd1);
    chk_acc("fr_acc", o_acc, AW'(4));
    chk("fr_tr", 16'(o_trunc), 16'd0);

    // reset while in OUT
    rst_n = 1'b0;
    #1;
    chk("or_ov", 16'(o_valid), 16'd0);
    chk("or_ird", 16'(i_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_scale_acc.md
# dot_scale_acc

Block-scaled accumulator directly downstream of `dot_fp_spec`. It consumes one dot-product result per cycle (`o_dp`, `o_nan`) together with the two E8M0 shared scales of the contributing MX blocks. It aligns each result to a running block exponent and accumulates a group of blocks into a wide fixed-point mantissa. At the end of the group it presents (mantissa, exponent, NaN, count) on a valid/ready output.

## Interface

Parameters:
- `in_width`, 43: width of `i_dp`; matches `dot_fp_spec` `o_dp` for E4M3 with k=32.
- `scale_width`, 8: E8M0 shared-scale width; value 0xFF is NaN.
- `max_blocks`, 16: maximum number of beats per group.
- `acc_width`, `in_width + $clog2(max_blocks)`: width of the accumulator and of `o_acc`.
- `cnt_width`, `$clog2(max_blocks+1)`: width of `o_cnt`.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: input beat valid.
- `i_ready`, out, 1: block accepts a beat this cycle.
- `i_dp`, in, `in_width`: signed dot product from `dot_fp_spec`.
- `i_nan`, in, 1: `o_nan` from `dot_fp_spec`.
- `i_xa`, in, `scale_width`: shared scale of vector A block.
- `i_xb`, in, `scale_width`: shared scale of vector B block.
- `i_last`, in, 1: beat is the final block of the group.
- `o_valid`, out, 1: group result valid.
- `o_ready`, in, 1: consumer accepts the result.
- `o_acc`, out, `acc_width`: signed accumulated mantissa.
- `o_exp`, out, 10: signed group exponent. Result value = `o_acc` × 2^`o_exp` in `i_dp` units.
- `o_nan`, out, 1: sticky NaN for the group.
- `o_cnt`, out, `cnt_width`: number of beats accumulated.
- `o_trunc`, out, 1: group was closed by `max_blocks` rather than by `i_last`.

## Operation

- FSM states: ACC (reset state) and OUT.
  - `i_ready` = (state == ACC).
  - `o_valid` = (state == OUT).
- Beat exponent: e = `i_xa` + `i_xb`, unsigned, 9 bits.
- Beat NaN: `i_nan`, or `i_xa` == 0xFF, or `i_xb` == 0xFF.
- On accept with cnt == 0 (first beat):
  - acc ← sext(`i_dp`); accE ← e; nan ← beat NaN; cnt ← 1.
- On accept with cnt > 0:
  - If e > accE: acc ← (acc >>> (e − accE)) + sext(`i_dp`); accE ← e.
  - Else: acc ← acc + (sext(`i_dp`) >>> (accE − e)).
  - nan ← nan | beat NaN; cnt ← cnt + 1.
- Shift rules:
  - All shifts are arithmetic, so rounding is truncation toward −∞.
  - A shift ≥ `acc_width` yields 0 for non-negative operands and −1 for negative operands.
- Acc arithmetic is two's complement at `acc_width`. By construction it cannot overflow within `max_blocks` beats.
- NaN beats still accumulate `i_dp`. The numeric output is don't-care whenever `o_nan` = 1, but it must still be deterministic.
- Group close:
  - An accepted beat with `i_last` = 1, or an accepted beat that makes cnt == `max_blocks`, moves the FSM to OUT.
  - `o_trunc` ← (`i_last` == 0).
- Output values while in OUT: `o_acc` = acc; `o_exp` = accE − 254; `o_nan` = nan; `o_cnt` = cnt.
- OUT → ACC on `o_valid` && `o_ready`. On that transition cnt ← 0 and `o_trunc` is cleared.
- Reset (any time, including mid-group or in OUT):
  - FSM → ACC.
  - acc, accE, nan, cnt, `o_trunc` → 0.
  - All outputs are 0, except `i_ready` = 1.

## Timing

- Beat accept happens on a rising edge with `i_valid` && `i_ready`. Accumulate completes in the same edge (1-cycle update).
- Throughput is 1 beat per cycle in ACC. An N-beat group occupies N cycles plus at least 1 cycle in OUT.
- `o_valid` rises on the cycle after the closing beat is accepted.
- `o_valid` and all output data stay stable until accepted. `o_ready` may be held low indefinitely.
- `i_ready` is low for the whole OUT state.
- `i_ready` returns high on the cycle after the output handshake. No input beat is accepted in the handshake cycle itself.
- The `i_*` data inputs are sampled only when a beat is accepted; otherwise they are ignored.

## Test plan

- Single beat: `i_dp`=100, `i_xa`=`i_xb`=127, `i_last`=1.
  - Next cycle: `o_valid`=1, `o_acc`=100, `o_exp`=0, `o_cnt`=1, `o_nan`=0, `o_trunc`=0.
- Equal scales, two beats: 5 then −3, both scales 127, last on beat 2.
  - `o_acc`=2, `o_exp`=0, `o_cnt`=2.
- Alignment, both orders:
  - Beat 1: dp=8 with e=254 (127+127). Beat 2: dp=1 with e=255 (128+127). Expect `o_acc`=5, `o_exp`=1.
  - Reversed order gives the same result.
  - dp=−3 (e=254) then dp=0 (e=255): expect `o_acc`=−2 (floor).
  - Scales 254/254 then 0/0: second beat contributes 0 for a positive dp and −1 for a negative dp.
- NaN:
  - `i_xa`=0xFF on beat 2 of 3 gives `o_nan`=1, `o_cnt`=3.
  - The next group with clean inputs gives `o_nan`=0.
- Backpressure: hold `o_ready`=0 for 3 cycles with `i_valid`=1.
  - `i_ready`=0 throughout; outputs unchanged.
  - Handshake on cycle 4; `i_ready`=1 on cycle 5.
- Truncation and reset:
  - 16 beats with `i_last`=0 give `o_valid`, `o_cnt`=16, `o_trunc`=1.
  - Assert `rst_n`=0 after 3 beats of a group: all outputs become 0 and `i_ready`=1.
  - The next group starts fresh with `o_cnt` counting from 1.
